// File: rtl/dkong_rom_loader.sv
// dkong_rom_loader: routes the hps_io ROM download into the core's four ROM regions
// and holds the core in reset during the load and for a fixed tail afterwards.
module dkong_rom_loader #(
   parameter int ADDR_W = 19,
   parameter int R0_END = 'h04000,
   parameter int R1_END = 'h05000,
   parameter int R2_END = 'h06000,
   parameter int R3_END = 'h08000,
   parameter int HOLD   = 16
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic              rst_req,
   output logic [3:0]        rgn_wr,
   output logic [15:0]       rgn_addr,
   output logic [7:0]        rgn_data,
   output logic              core_reset,
   output logic              loaded,
   output logic [19:0]       byte_cnt,
   output logic [1:0]        err
);
   localparam int TW = $clog2(HOLD + 1);
   localparam logic [ADDR_W-1:0] E0 = ADDR_W'(R0_END);
   localparam logic [ADDR_W-1:0] E1 = ADDR_W'(R1_END);
   localparam logic [ADDR_W-1:0] E2 = ADDR_W'(R2_END);
   localparam logic [ADDR_W-1:0] E3 = ADDR_W'(R3_END);
   localparam logic [15:0] B1 = 16'(R0_END);
   localparam logic [15:0] B2 = 16'(R1_END);
   localparam logic [15:0] B3 = 16'(R2_END);
   localparam logic [19:0] TOTAL = 20'(R3_END);
   localparam logic [TW-1:0] HOLD_V = TW'(HOLD);
   localparam logic [TW-1:0] ONE = TW'(1);

   typedef enum logic [1:0] {IDLE, LOAD, TAIL, RUN} state_t;

   state_t state_q, state_d;
   logic dl_q;
   logic [TW-1:0] tail_q, tail_d;
   logic [3:0] rgn_wr_q, rgn_wr_d;
   logic [15:0] rgn_addr_q, rgn_addr_d;
   logic [7:0] rgn_data_q, rgn_data_d;
   logic core_reset_q, core_reset_d;
   logic loaded_q, loaded_d;
   logic [19:0] byte_cnt_q, byte_cnt_d;
   logic [1:0] err_q, err_d;

   logic rise, fall, wr_en;
   logic [3:0] sel;
   logic [15:0] base;
   logic [19:0] cnt_inc, cnt_fin;

   always_comb begin
      rise = ioctl_download & ~dl_q;
      fall = ~ioctl_download & dl_q;
      wr_en = ioctl_wr & (state_q == LOAD) & ~rise;
      sel = ioctl_addr < E0 ? 4'b0001 :
            ioctl_addr < E1 ? 4'b0010 :
            ioctl_addr < E2 ? 4'b0100 :
            ioctl_addr < E3 ? 4'b1000 : 4'b0000;
      base = sel[0] ? 16'd0 : sel[1] ? B1 : sel[2] ? B2 : B3;
      cnt_inc = &byte_cnt_q ? byte_cnt_q : byte_cnt_q + 20'd1;
      cnt_fin = wr_en ? cnt_inc : byte_cnt_q;
      state_d = state_q;
      tail_d = tail_q;
      rgn_wr_d = wr_en ? sel : 4'b0000;
      rgn_addr_d = (wr_en && sel != 4'b0000) ? ioctl_addr[15:0] - base : rgn_addr_q;
      rgn_data_d = (wr_en && sel != 4'b0000) ? ioctl_dout : rgn_data_q;
      byte_cnt_d = cnt_fin;
      err_d = {err_q[1] | (wr_en & (sel == 4'b0000)), err_q[0]};
      loaded_d = loaded_q;
      if (rise) begin
         state_d = LOAD;
         byte_cnt_d = '0;
         err_d = '0;
         loaded_d = 1'b0;
         rgn_wr_d = '0;
      end else if (state_q == LOAD && fall) begin
         state_d = cnt_fin == '0 ? IDLE : TAIL;
         tail_d = HOLD_V;
         err_d[0] = err_q[0] | (cnt_fin < TOTAL);
      end else if (state_q == TAIL) begin
         // a held rst_req keeps the tail pinned at full length
         if (rst_req) tail_d = HOLD_V;
         else if (tail_q == ONE) begin
            state_d = RUN;
            loaded_d = 1'b1;
         end else tail_d = tail_q - ONE;
      end else if (state_q == RUN && rst_req) begin
         state_d = TAIL;
         tail_d = HOLD_V;
      end
      core_reset_d = state_d != RUN;
   end

   always_ff @(posedge clk_sys) begin
      dl_q <= ioctl_download;
      if (reset) begin
         state_q <= IDLE;
         tail_q <= '0;
         rgn_wr_q <= '0;
         rgn_addr_q <= '0;
         rgn_data_q <= '0;
         core_reset_q <= 1'b1;
         loaded_q <= 1'b0;
         byte_cnt_q <= '0;
         err_q <= '0;
      end else begin
         state_q <= state_d;
         tail_q <= tail_d;
         rgn_wr_q <= rgn_wr_d;
         rgn_addr_q <= rgn_addr_d;
         rgn_data_q <= rgn_data_d;
         core_reset_q <= core_reset_d;
         loaded_q <= loaded_d;
         byte_cnt_q <= byte_cnt_d;
         err_q <= err_d;
      end
   end

   assign rgn_wr = rgn_wr_q;
   assign rgn_addr = rgn_addr_q;
   assign rgn_data = rgn_data_q;
   assign core_reset = core_reset_q;
   assign loaded = loaded_q;
   assign byte_cnt = byte_cnt_q;
   assign err = err_q;
endmodule

// File: doc/dkong_rom_loader.md
Name: dkong_rom_loader

Overview:
- Sequences ROM download from the HPS ioctl stream into the Donkey Kong core's ROM regions.
- Decodes each download byte to one of four contiguous regions and emits a one-hot write strobe with a region-local address.
- Holds the core in reset during download and for a fixed tail afterwards; also re-times user reset requests.
- Reports load status (byte count, short-load and overflow errors). Sits between hps_io and dkong_top.

Parameters:
- ADDR_W, 19, width of ioctl_addr.
- R0_END, 'h04000, exclusive end of region 0 (main CPU ROM); region 0 starts at 0.
- R1_END, 'h05000, exclusive end of region 1 (sound CPU ROM).
- R2_END, 'h06000, exclusive end of region 2 (tile gfx).
- R3_END, 'h08000, exclusive end of region 3 (sprite gfx); this is also the expected total size.
- HOLD, 16, number of clk_sys cycles core_reset stays high after a load or reset request.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download-active level from hps_io.
- ioctl_wr  in  1  one-cycle byte-valid strobe.
- ioctl_addr  in  ADDR_W  byte address.
- ioctl_dout  in  8  byte data.
- rst_req  in  1  user/OSD reset request (level).
- rgn_wr  out  4  one-hot region write strobe, one cycle wide.
- rgn_addr  out  16  region-local address (ioctl_addr minus region base, low 16 bits).
- rgn_data  out  8  byte to write.
- core_reset  out  1  active-high reset to the core.
- loaded  out  1  a complete load has finished and the core is running.
- byte_cnt  out  20  bytes received in the current or last load, saturating at 'hFFFFF.
- err  out  2  bit0 = short load, bit1 = address overflow; sticky until the next load starts.

Behaviour:
- States: IDLE, LOAD, TAIL, RUN. Only sequential logic; no combinational outputs.
- Reset: state goes to IDLE. rgn_wr=0, rgn_addr=0, rgn_data=0, core_reset=1, loaded=0, byte_cnt=0, err=0, tail counter=0. A reset asserted mid-load aborts the load and produces no further strobes.
- Download edge detection uses a registered copy of ioctl_download.
- IDLE: core_reset=1.
  - On a rising edge of ioctl_download → LOAD.
  - rst_req is ignored.
- Rising edge of ioctl_download in any state → LOAD. On that cycle, byte_cnt=0, err=0, loaded=0, core_reset=1.
- LOAD: each ioctl_wr is registered and produces outputs on the next cycle (latency 1):
  - addr < R0_END → rgn_wr=0001, rgn_addr=addr.
  - addr < R1_END → rgn_wr=0010, rgn_addr=addr−R0_END.
  - addr < R2_END → rgn_wr=0100, rgn_addr=addr−R1_END.
  - addr < R3_END → rgn_wr=1000, rgn_addr=addr−R2_END.
  - otherwise no strobe and err[1] is set.
  - rgn_data = ioctl_dout in all cases.
  - byte_cnt increments on every ioctl_wr, including overflow bytes, and saturates.
  - rgn_addr and rgn_data hold their value when there is no strobe.
- ioctl_wr outside LOAD is ignored: no strobe, no count.
- Falling edge of ioctl_download in LOAD:
  - If byte_cnt == 0 (counting an ioctl_wr on the same cycle) → IDLE.
  - Otherwise → TAIL and the tail counter is loaded with HOLD.
  - In both cases err[0] is set if the final count < R3_END.
  - An ioctl_wr on the same cycle as the fall is still processed: strobe and count.
- TAIL: core_reset=1 and the counter decrements each cycle. When it reaches 1 → RUN with loaded=1, so core_reset is high for exactly HOLD cycles after the falling-edge cycle.
- RUN: core_reset=0 while rst_req=0.
  - rst_req=1 → TAIL with counter=HOLD and loaded kept at 1.
  - If rst_req stays high, TAIL stays pinned at HOLD until it falls.
  - A download rising edge takes priority over rst_req.
- Simultaneous download rise and ioctl_wr: the state change is taken and the byte is ignored, because hps_io never writes on the rise cycle.

Test Plan:
- Reset, then idle 10 cycles → core_reset=1, loaded=0, rgn_wr=0, err=0.
- Download bytes at addr 0, 'h3FFF, 'h4000, 'h5000, 'h6000 and 'h7FFF, with data = addr[7:0] → rgn_wr = 0001, 0001, 0010, 0100, 1000, 1000 respectively. Matching rgn_addr = 0, 'h3FFF, 0, 0, 0, 'h1FFF. Each strobe appears 1 cycle after its ioctl_wr; byte_cnt=6.
- Full load of 'h8000 bytes, then drop download → err=00. core_reset stays high exactly 16 cycles after the fall; then loaded=1 and core_reset=0.
- Load 'h100 bytes, then one byte at 'h8000 → no strobe for the 'h8000 byte, byte_cnt='h101, err=11 after the fall; core still enters RUN.
- In RUN, pulse rst_req for 1 cycle → core_reset=1 for 16 cycles, loaded stays 1. Start a new download → loaded=0 and byte_cnt=0 on the rise.
- Assert reset mid-load after 'h40 bytes, with further ioctl_wr pulses → no strobes, state IDLE, byte_cnt=0. Download rise then fall with no bytes → returns to IDLE, core_reset remains 1.
